// File: rtl/vip_pkg.sv
// Shared definitions for the VIP rank-filter stage.
// Contents: per-frame filter mode encodings, border fill encodings and the
// fixed pipeline latency of the 3x3 rank filter.
package vip_pkg;

    typedef enum logic [1:0] {
        MODE_MED = 2'd0,
        MODE_MIN = 2'd1,
        MODE_MAX = 2'd2,
        MODE_BYP = 2'd3
    } mode_e;

    localparam int unsigned BORDER_REPL = 0;
    localparam int unsigned BORDER_ZERO = 1;

    // Window register plus three sort stages.
    localparam int unsigned LAT = 4;

endpackage

// File: rtl/vip_sort3.sv
// Combinational three-input sorter (unsigned compare, no width growth).
// Ports:
//   a, b, c  in  DW  operands
//   max_v    out DW  largest operand
//   mid_v    out DW  median operand
//   min_v    out DW  smallest operand
module vip_sort3 #(
    parameter int unsigned DW = 8
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] c,
    output logic [DW-1:0] max_v,
    output logic [DW-1:0] mid_v,
    output logic [DW-1:0] min_v
);

    logic [DW-1:0] hi_ab;
    logic [DW-1:0] lo_ab;

    always_comb begin
        hi_ab = (a > b) ? a : b;
        lo_ab = (a > b) ? b : a;
        max_v = (hi_ab > c) ? hi_ab : c;
        min_v = (lo_ab < c) ? lo_ab : c;
        if (c > hi_ab) begin
            mid_v = hi_ab;
        end else if (c < lo_ab) begin
            mid_v = lo_ab;
        end else begin
            mid_v = c;
        end
    end

endmodule

// File: rtl/vip_rank_filter_3x3.sv
// 3x3 rank filter on a raster gray stream: median, min (erode), max (dilate)
// or bypass, selected per frame, with replicate/zero border fill.
// Ports:
//   clk, rst_n                          pixel clock, async active-low reset
//   pre_frame_vsync/href/clken          input frame sync, line valid, strobe
//   pre_img_y                           input pixel (DW bits)
//   mode                                0 med, 1 min, 2 max, 3 bypass
//   pos_frame_vsync/href/clken          input controls delayed LAT cycles
//   pos_img_y                           filtered pixel, 0 outside href
module vip_rank_filter_3x3
    import vip_pkg::*;
#(
    parameter int unsigned DW     = 8,
    parameter int unsigned IMG_W  = 1024,
    parameter int unsigned BORDER = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pre_frame_vsync,
    input  logic          pre_frame_href,
    input  logic          pre_frame_clken,
    input  logic [DW-1:0] pre_img_y,
    input  logic [1:0]    mode,
    output logic          pos_frame_vsync,
    output logic          pos_frame_href,
    output logic          pos_frame_clken,
    output logic [DW-1:0] pos_img_y
);

    localparam int unsigned CW = $clog2(IMG_W + 1);
    localparam int unsigned AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam bit FILL_ZERO   = (BORDER == BORDER_ZERO);

    // Line buffers: lb1 holds the previous line, lb0 the one before it.
    logic [DW-1:0] lb0 [IMG_W];
    logic [DW-1:0] lb1 [IMG_W];

    logic [CW-1:0] col;
    logic [1:0]    row;        // saturates at 2: only "top", "second", "rest" matter
    logic          href_q;
    logic          vsync_q;
    mode_e         mode_q;

    logic          vs_rise, href_fall, accept, ovf;
    logic [1:0]    row_eff;
    mode_e         mode_eff;
    logic [AW-1:0] addr;
    logic [DW-1:0] rd0, rd1;

    // Column vectors indexed [0]=oldest row, [1]=middle row, [2]=current row.
    logic [2:0][DW-1:0] cur_col, prev1, prev2, col_l, col_m;
    logic [2:0][2:0][DW-1:0] win_d, win_q;   // [row][col], col 0 = leftmost
    mode_e win_mode_q;

    logic [2:0][DW-1:0] s1_max, s1_mid, s1_min;
    logic [2:0][DW-1:0] s1_max_q, s1_mid_q, s1_min_q;
    logic [DW-1:0]      s1_ctr_q;
    mode_e              s1_mode_q;
    logic [DW-1:0]      hi_max, hi_mid, hi_min, md_max, md_mid, md_min;
    logic [DW-1:0]      lo_max, lo_mid, lo_min, s3_max, s3_mid, s3_min;
    logic [2:0][DW-1:0] s2_d, s2_q;
    logic [2:0]         vs_d, hr_d, ce_d;

    // A vsync rise in the same cycle as a pixel applies before that pixel.
    assign vs_rise   = pre_frame_vsync & ~vsync_q;
    assign href_fall = href_q & ~pre_frame_href;
    assign accept    = pre_frame_clken & pre_frame_href;
    assign row_eff   = vs_rise ? 2'd0 : row;
    assign mode_eff  = vs_rise ? mode_e'(mode) : mode_q;
    assign ovf       = (col >= CW'(IMG_W));
    assign addr      = ovf ? '0 : col[AW-1:0];
    assign rd0       = lb0[addr];
    assign rd1       = lb1[addr];

    always_comb begin
        cur_col[2] = pre_img_y;
        cur_col[1] = rd1;
        cur_col[0] = rd0;
        if (row_eff == 2'd0) begin
            cur_col[1] = FILL_ZERO ? '0 : pre_img_y;
            cur_col[0] = FILL_ZERO ? '0 : pre_img_y;
        end else if (row_eff == 2'd1) begin
            cur_col[0] = FILL_ZERO ? '0 : rd1;
        end

        col_m = prev1;
        col_l = prev2;
        if (col == '0) begin
            col_m = FILL_ZERO ? '0 : cur_col;
            col_l = FILL_ZERO ? '0 : cur_col;
        end else if (col == CW'(1)) begin
            col_l = FILL_ZERO ? '0 : prev1;
        end

        for (int i = 0; i < 3; i++) begin
            win_d[i][0] = col_l[i];
            win_d[i][1] = col_m[i];
            win_d[i][2] = cur_col[i];
        end
        // Overflowed pixels pass through raw via the bypass path.
        if (ovf) begin
            win_d[1][1] = pre_img_y;
        end
    end

    // Line-buffer RAM is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (accept && !ovf) begin
            lb1[addr] <= pre_img_y;
            lb0[addr] <= rd1;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_s1
        vip_sort3 #(.DW(DW)) u_s1 (
            .a    (win_q[i][0]),
            .b    (win_q[i][1]),
            .c    (win_q[i][2]),
            .max_v(s1_max[i]),
            .mid_v(s1_mid[i]),
            .min_v(s1_min[i])
        );
    end

    vip_sort3 #(.DW(DW)) u_s2_hi (
        .a(s1_max_q[0]), .b(s1_max_q[1]), .c(s1_max_q[2]),
        .max_v(hi_max), .mid_v(hi_mid), .min_v(hi_min)
    );
    vip_sort3 #(.DW(DW)) u_s2_md (
        .a(s1_mid_q[0]), .b(s1_mid_q[1]), .c(s1_mid_q[2]),
        .max_v(md_max), .mid_v(md_mid), .min_v(md_min)
    );
    vip_sort3 #(.DW(DW)) u_s2_lo (
        .a(s1_min_q[0]), .b(s1_min_q[1]), .c(s1_min_q[2]),
        .max_v(lo_max), .mid_v(lo_mid), .min_v(lo_min)
    );
    vip_sort3 #(.DW(DW)) u_s3 (
        .a(s2_q[0]), .b(s2_q[1]), .c(s2_q[2]),
        .max_v(s3_max), .mid_v(s3_mid), .min_v(s3_min)
    );

    logic unused_sort;
    assign unused_sort = ^{hi_mid, md_max, md_min, lo_mid, s3_max, s3_min};

    // Non-median modes replicate their result so the final median passes it.
    always_comb begin
        s2_d = {3{s1_ctr_q}};
        case (s1_mode_q)
            MODE_MED: s2_d = {lo_max, md_mid, hi_min};
            MODE_MIN: s2_d = {3{lo_min}};
            MODE_MAX: s2_d = {3{hi_max}};
            default:  s2_d = {3{s1_ctr_q}};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col             <= '0;
            row             <= '0;
            href_q          <= 1'b0;
            vsync_q         <= 1'b0;
            mode_q          <= MODE_MED;
            prev1           <= '0;
            prev2           <= '0;
            win_q           <= '0;
            win_mode_q      <= MODE_MED;
            s1_max_q        <= '0;
            s1_mid_q        <= '0;
            s1_min_q        <= '0;
            s1_ctr_q        <= '0;
            s1_mode_q       <= MODE_MED;
            s2_q            <= '0;
            vs_d            <= '0;
            hr_d            <= '0;
            ce_d            <= '0;
            pos_frame_vsync <= 1'b0;
            pos_frame_href  <= 1'b0;
            pos_frame_clken <= 1'b0;
            pos_img_y       <= '0;
        end else begin
            href_q  <= pre_frame_href;
            vsync_q <= pre_frame_vsync;
            if (vs_rise) begin
                mode_q <= mode_e'(mode);
                row    <= 2'd0;
            end else if (href_fall && row != 2'd2) begin
                row <= row + 2'd1;
            end
            if (href_fall) begin
                col <= '0;
            end else if (accept && !ovf) begin
                col <= col + CW'(1);
            end
            if (accept) begin
                prev2      <= prev1;
                prev1      <= cur_col;
                win_q      <= win_d;
                win_mode_q <= ovf ? MODE_BYP : mode_eff;
            end

            s1_max_q  <= s1_max;
            s1_mid_q  <= s1_mid;
            s1_min_q  <= s1_min;
            s1_ctr_q  <= win_q[1][1];
            s1_mode_q <= win_mode_q;
            s2_q      <= s2_d;
            pos_img_y <= hr_d[2] ? s3_mid : '0;

            vs_d            <= {vs_d[1:0], pre_frame_vsync};
            hr_d            <= {hr_d[1:0], pre_frame_href};
            ce_d            <= {ce_d[1:0], pre_frame_clken};
            pos_frame_vsync <= vs_d[2];
            pos_frame_href  <= hr_d[2];
            pos_frame_clken <= ce_d[2];
        end
    end

endmodule

// File: tb/tb_vip_rank_filter_3x3.sv
module tb_vip_rank_filter_3x3;

    localparam int W = 8;
    localparam int H = 8;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        vs    = 1'b0;
    logic        hr    = 1'b0;
    logic        ce    = 1'b0;
    logic [11:0] pix   = '0;
    logic [1:0]  mode  = 2'd0;

    logic        a_vs, a_hr, a_ce;
    logic [7:0]  a_y;
    logic        b_vs, b_hr, b_ce;
    logic [11:0] b_y;

    always #5 clk = ~clk;

    // 8-bit replicate-border instance and 12-bit zero-border instance.
    vip_rank_filter_3x3 #(.DW(8), .IMG_W(W), .BORDER(0)) u_dut_a (
        .clk            (clk),
        .rst_n          (rst_n),
        .pre_frame_vsync(vs),
        .pre_frame_href (hr),
        .pre_frame_clken(ce),
        .pre_img_y      (pix[7:0]),
        .mode           (mode),
        .pos_frame_vsync(a_vs),
        .pos_frame_href (a_hr),
        .pos_frame_clken(a_ce),
        .pos_img_y      (a_y)
    );

    vip_rank_filter_3x3 #(.DW(12), .IMG_W(W), .BORDER(1)) u_dut_b (
        .clk            (clk),
        .rst_n          (rst_n),
        .pre_frame_vsync(vs),
        .pre_frame_href (hr),
        .pre_frame_clken(ce),
        .pre_img_y      (pix),
        .mode           (mode),
        .pos_frame_vsync(b_vs),
        .pos_frame_href (b_hr),
        .pos_frame_clken(b_ce),
        .pos_img_y      (b_y)
    );

    int img [16][16];
    int frame_mode = 0;
    int npass = 0;
    int nchk  = 0;
    int q_vs[$], q_hr[$], q_ce[$], q_ya[$], q_yb[$];

    // Reference: 3x3 window over rows r-2..r, cols c-2..c, missing
    // coordinates clamped (replicate) or zero; rank taken by full sort.
    function automatic int model(int border, int mask, int r, int c, int md);
        int v[9];
        int n;
        int t;
        int rr;
        int cc;
        n = 0;
        if (c >= W) return img[r][c] & mask;
        for (int dr = -2; dr <= 0; dr++) begin
            for (int dc = -2; dc <= 0; dc++) begin
                rr = r + dr;
                cc = c + dc;
                if (rr < 0 || cc < 0) begin
                    v[n] = (border == 1) ? 0 :
                           (img[(rr < 0) ? 0 : rr][(cc < 0) ? 0 : cc] & mask);
                end else begin
                    v[n] = img[rr][cc] & mask;
                end
                n++;
            end
        end
        if (md == 3) return v[4];
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < 8 - i; j++) begin
                if (v[j] > v[j+1]) begin
                    t = v[j]; v[j] = v[j+1]; v[j+1] = t;
                end
            end
        end
        if (md == 1) return v[0];
        if (md == 2) return v[8];
        return v[4];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic push(input int v, input int h, input int e, input int ya, input int yb);
        q_vs.push_back(v); q_hr.push_back(h); q_ce.push_back(e);
        q_ya.push_back(ya); q_yb.push_back(yb);
    endtask

    // Drive one cycle, then check the outputs owed for the entry 3 cycles back.
    task automatic step(input bit v, input bit h, input bit e, input int p,
                        input int r, input int c);
        int ya;
        int yb;
        vs = v; hr = h; ce = e; pix = p[11:0];
        if (h && e) img[r][c] = p & 32'hFFF;
        ya = !h ? 0 : (e ? model(0, 255, r, c, frame_mode) : -1);
        yb = !h ? 0 : (e ? model(1, 4095, r, c, frame_mode) : -1);
        push(v, h, e, ya, yb);
        @(posedge clk);
        #1;
        if (q_vs.size() >= 4) begin
            int ev, eh, ee, ea, eb;
            ev = q_vs.pop_front(); eh = q_hr.pop_front(); ee = q_ce.pop_front();
            ea = q_ya.pop_front(); eb = q_yb.pop_front();
            chk("a_vsync", a_vs, ev);
            chk("a_href", a_hr, eh);
            chk("a_clken", a_ce, ee);
            chk("b_vsync", b_vs, ev);
            chk("b_href", b_hr, eh);
            chk("b_clken", b_ce, ee);
            if (ea != -1) chk("a_pixel", a_y, ea);
            if (eb != -1) chk("b_pixel", b_y, eb);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; vs = 1'b0; hr = 1'b0; ce = 1'b0;
        #1;
        chk("rst_a_vsync", a_vs, 0);
        chk("rst_a_href", a_hr, 0);
        chk("rst_a_clken", a_ce, 0);
        chk("rst_a_pixel", a_y, 0);
        chk("rst_b_vsync", b_vs, 0);
        chk("rst_b_href", b_hr, 0);
        chk("rst_b_clken", b_ce, 0);
        chk("rst_b_pixel", b_y, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        q_vs.delete(); q_hr.delete(); q_ce.delete(); q_ya.delete(); q_yb.delete();
        for (int i = 0; i < 3; i++) push(0, 0, 0, 0, 0);
        frame_mode = 0;
    endtask

    function automatic int pix_of(input int kind, input int r, input int c);
        case (kind)
            0:       return 8 * r + c;
            1:       return (r == 3 && c == 3) ? 255 : 20;
            4:       return ($urandom_range(0, 1) == 1) ? 4095 : int'($urandom_range(0, 4095));
            default: return int'($urandom_range(0, 4095));
        endcase
    endfunction

    // vsm: 0 vsync pulse before frame, 1 vsync rises on first pixel, 2 no vsync.
    task automatic run_frame(input int kind, input int m, input int m_mid, input bit gaps,
                             input int ovf_row, input int vsm, input bit abort);
        int wl;
        mode = m[1:0];
        if (vsm != 2) frame_mode = m;
        if (vsm == 0) begin
            step(1, 0, 0, 0, 0, 0);
            step(1, 0, 0, 0, 0, 0);
            idle(3);
        end
        for (int r = 0; r < H; r++) begin
            if (r == 4 && m_mid >= 0) mode = m_mid[1:0];
            wl = (r == ovf_row) ? 10 : W;
            for (int c = 0; c < wl; c++) begin
                if (abort && r == 4 && c == 3) return;
                if (gaps && $urandom_range(0, 1) == 1)
                    step(0, 1, 0, int'($urandom_range(0, 4095)), r, c);
                step((vsm == 1 && r == 0 && c == 0), 1, 1, pix_of(kind, r, c), r, c);
            end
            idle(5);
        end
    endtask

    initial begin
        #2;
        do_reset();
        idle(4);
        run_frame(0, 0, -1, 0, -1, 0, 0);   // ramp, median
        run_frame(1, 0, -1, 0, -1, 0, 0);   // impulse, median
        run_frame(1, 2, -1, 0, -1, 0, 0);   // impulse, max
        run_frame(1, 1, -1, 0, -1, 0, 0);   // impulse, min
        run_frame(2, 0, 2, 0, -1, 0, 0);    // mode change mid-frame
        run_frame(2, 2, -1, 0, -1, 0, 0);   // next frame takes max
        run_frame(2, 0, -1, 1, 2, 0, 0);    // overflow line, clken gaps
        run_frame(2, 1, -1, 0, 5, 0, 0);    // overflow line, min
        run_frame(0, 3, -1, 1, -1, 1, 0);   // bypass, vsync on first pixel
        run_frame(4, 2, -1, 0, -1, 0, 1);   // aborted by reset mid-line 4
        do_reset();
        idle(3);
        run_frame(2, 2, -1, 0, -1, 2, 0);   // post-reset lines, no vsync
        run_frame(4, 0, -1, 1, -1, 0, 0);   // full-scale 12-bit values
        idle(6);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
